// File: rtl/quad_enc_pkg.sv
// Shared types and default constants for the quadrature encoder input filter.
package quad_enc_pkg;

    // Default number of synchroniser flops per raw pin (legal range 2-4)
    localparam int SYNC_STAGES_DEF  = 2;
    // Default width of the filter-length register and of each filter counter
    localparam int FILT_W_DEF       = 8;
    // Filter length loaded at reset
    localparam int FILT_DEFAULT_DEF = 3;
    // Width of the saturating phase-error counter
    localparam int ERR_W            = 16;

    // PRIME seeds the filtered outputs after reset; RUN is normal operation
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/quad_enc_filter_if.sv
// Bus between the encoder pins/control and the filtered outputs.
interface quad_enc_filter_if #(
    parameter int FILT_W = quad_enc_pkg::FILT_W_DEF
);
    import quad_enc_pkg::*;

    logic              quadA_raw;
    logic              quadB_raw;
    logic              index_raw;
    logic [FILT_W-1:0] filt_len;
    logic              filt_wr;
    logic              err_clr;
    logic              quadA;
    logic              quadB;
    logic              index_strobe;
    logic              phase_err;
    logic [ERR_W-1:0]  err_count;

    // Side that drives the pins and control, and consumes the filtered results
    modport master (
        output quadA_raw, quadB_raw, index_raw, filt_len, filt_wr, err_clr,
        input  quadA, quadB, index_strobe, phase_err, err_count
    );

    // The filter block itself
    modport slave (
        input  quadA_raw, quadB_raw, index_raw, filt_len, filt_wr, err_clr,
        output quadA, quadB, index_strobe, phase_err, err_count
    );

endinterface

// File: rtl/quad_enc_glitch_filt.sv
// One encoder channel: synchroniser chain followed by a stable-count glitch filter.
module quad_enc_glitch_filt
    import quad_enc_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_W      = FILT_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              raw_i,
    input  logic [FILT_W-1:0] filt_len_i,
    input  logic              cnt_clr_i,
    input  logic              prime_i,
    input  logic              load_i,
    output logic              filt_o,
    output logic              toggle_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign filt_o = filt_q;

    // Shift the raw pin into the synchroniser; only the last stage is used downstream
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Counter filter: the output only follows a synced value that has disagreed
    // with it for filt_len+1 consecutive cycles; a length write restarts the count
    always_comb begin
        cnt_d    = cnt_q;
        filt_d   = filt_q;
        toggle_o = 1'b0;
        if (load_i) begin
            filt_d = synced;
            cnt_d  = '0;
        end else if (prime_i || cnt_clr_i) begin
            cnt_d = '0;
        end else if (synced == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == filt_len_i) begin
            filt_d   = synced;
            cnt_d    = '0;
            toggle_o = 1'b1;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Channel state registers, cleared by reset so any pending transition is lost
    always_ff @(posedge clk_i) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/quad_enc_filter.sv
// Quadrature encoder input conditioning: three filtered channels, index edge
// strobe, A/B phase-error detection with a saturating error counter.
module quad_enc_filter
    import quad_enc_pkg::*;
#(
    parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int FILT_W       = FILT_W_DEF,
    parameter int FILT_DEFAULT = FILT_DEFAULT_DEF
) (
    input  logic             clk_i,
    input  logic             reset,
    quad_enc_filter_if.slave bus
);

    ctrl_state_t       state_q, state_d;
    logic [2:0]        primeCnt_q, primeCnt_d;
    logic              inPrime;
    logic              primeLoad;
    logic [FILT_W-1:0] filtLen_q, filtLen_d;
    logic              aFilt, bFilt, idxFilt;
    logic              aTog, bTog, idxTog;
    logic              idxRise_q, idxRise_d;
    logic              strobe_q, strobe_d;
    logic              phaseErr_q, phaseErr_d;
    logic [ERR_W-1:0]  errCount_q, errCount_d;
    logic              bothToggle;

    quad_enc_glitch_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filtA (
        .clk_i      (clk_i),
        .reset      (reset),
        .raw_i      (bus.quadA_raw),
        .filt_len_i (filtLen_q),
        .cnt_clr_i  (bus.filt_wr),
        .prime_i    (inPrime),
        .load_i     (primeLoad),
        .filt_o     (aFilt),
        .toggle_o   (aTog)
    );

    quad_enc_glitch_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filtB (
        .clk_i      (clk_i),
        .reset      (reset),
        .raw_i      (bus.quadB_raw),
        .filt_len_i (filtLen_q),
        .cnt_clr_i  (bus.filt_wr),
        .prime_i    (inPrime),
        .load_i     (primeLoad),
        .filt_o     (bFilt),
        .toggle_o   (bTog)
    );

    quad_enc_glitch_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filtIdx (
        .clk_i      (clk_i),
        .reset      (reset),
        .raw_i      (bus.index_raw),
        .filt_len_i (filtLen_q),
        .cnt_clr_i  (bus.filt_wr),
        .prime_i    (inPrime),
        .load_i     (primeLoad),
        .filt_o     (idxFilt),
        .toggle_o   (idxTog)
    );

    // PRIME waits for the synchronisers to fill, then seeds the outputs once
    always_comb begin
        state_d    = state_q;
        primeCnt_d = primeCnt_q;
        inPrime    = 1'b0;
        primeLoad  = 1'b0;
        case (state_q)
            PRIME: begin
                inPrime = 1'b1;
                if (primeCnt_q == 3'(SYNC_STAGES)) begin
                    primeLoad  = 1'b1;
                    primeCnt_d = '0;
                    state_d    = RUN;
                end else begin
                    primeCnt_d = primeCnt_q + 3'd1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = PRIME;
            end
        endcase
    end

    // Control FSM registers
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_q    <= PRIME;
            primeCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            primeCnt_q <= primeCnt_d;
        end
    end

    // Index strobe lags the filtered rise by one cycle; phase errors are counted
    // when both A and B flip on the same edge, with a same-cycle clear losing
    assign bothToggle = aTog & bTog;

    always_comb begin
        filtLen_d  = bus.filt_wr ? bus.filt_len : filtLen_q;
        idxRise_d  = idxTog & ~idxFilt;
        strobe_d   = strobe_q;
        phaseErr_d = phaseErr_q;
        errCount_d = errCount_q;
        if (!inPrime) begin
            strobe_d = idxRise_q;
            if (bus.err_clr) begin
                phaseErr_d = 1'b0;
                errCount_d = '0;
            end
            if (bothToggle) begin
                phaseErr_d = 1'b1;
                if (errCount_d != '1) begin
                    errCount_d = errCount_d + 1'b1;
                end
            end
        end
    end

    // Datapath registers: filter length, edge/strobe flags and error status
    always_ff @(posedge clk_i) begin
        if (reset) begin
            filtLen_q  <= FILT_W'(FILT_DEFAULT);
            idxRise_q  <= 1'b0;
            strobe_q   <= 1'b0;
            phaseErr_q <= 1'b0;
            errCount_q <= '0;
        end else begin
            filtLen_q  <= filtLen_d;
            idxRise_q  <= idxRise_d;
            strobe_q   <= strobe_d;
            phaseErr_q <= phaseErr_d;
            errCount_q <= errCount_d;
        end
    end

    assign bus.quadA        = aFilt;
    assign bus.quadB        = bFilt;
    assign bus.index_strobe = strobe_q;
    assign bus.phase_err    = phaseErr_q;
    assign bus.err_count    = errCount_q;

endmodule

// File: tb/tb_quad_enc_filter.sv
// Scoreboard bench for quad_enc_filter: stimulus queues expected output events,
// a negedge monitor pops and compares each output change it observes.
module tb_quad_enc_filter;

    localparam int K_A   = 0;
    localparam int K_B   = 1;
    localparam int K_STB = 2;
    localparam int K_PE  = 3;
    localparam int K_CNT = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] val;
    } evt_t;

    logic clk = 1'b0;
    logic reset;
    int   cycle = 0;
    bit   finishReq = 1'b0;
    int   checks = 0;
    int   errors = 0;
    evt_t expQ[$];

    logic        prevA, prevB, prevPe, prevRst;
    logic [15:0] prevCnt;

    quad_enc_filter_if #(.FILT_W(8)) bus();

    quad_enc_filter #(.SYNC_STAGES(2), .FILT_W(8), .FILT_DEFAULT(3)) dut (
        .clk_i (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic string kindName(input int kind);
        case (kind)
            K_A:     return "quadA";
            K_B:     return "quadB";
            K_STB:   return "index_strobe";
            K_PE:    return "phase_err";
            default: return "err_count";
        endcase
    endfunction

    task automatic expectEvent(input int cyc, input int kind, input logic [15:0] val);
        evt_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = val;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic observe(input int kind, input logic [15:0] val);
        evt_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_%s at cycle %0d: got %0h, expected no event", kindName(kind), cycle, val);
        end else begin
            e = expQ.pop_front();
            if (e.cyc != cycle || e.kind != kind || e.val !== val) begin
                errors++;
                $display("[TB] FAIL event_%s: got %s=%0h at cycle %0d, expected %s=%0h at cycle %0d",
                         kindName(kind), kindName(kind), val, cycle, kindName(e.kind), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every output change (or strobe high) is one event matched against the queue
    always @(negedge clk) begin
        if (reset) begin
            prevA   = 1'b0;
            prevB   = 1'b0;
            prevPe  = 1'b0;
            prevCnt = 16'h0;
            prevRst = 1'b1;
        end else begin
            if (prevRst) begin
                checkOutput("rst_quadA", {15'b0, bus.quadA}, 16'h0);
                checkOutput("rst_quadB", {15'b0, bus.quadB}, 16'h0);
                checkOutput("rst_index_strobe", {15'b0, bus.index_strobe}, 16'h0);
                checkOutput("rst_phase_err", {15'b0, bus.phase_err}, 16'h0);
                checkOutput("rst_err_count", bus.err_count, 16'h0);
            end
            prevRst = 1'b0;
            if (bus.quadA !== prevA) observe(K_A, {15'b0, bus.quadA});
            if (bus.quadB !== prevB) observe(K_B, {15'b0, bus.quadB});
            if (bus.index_strobe !== 1'b0) observe(K_STB, {15'b0, bus.index_strobe});
            if (bus.phase_err !== prevPe) observe(K_PE, {15'b0, bus.phase_err});
            if (bus.err_count !== prevCnt) observe(K_CNT, bus.err_count);
            prevA   = bus.quadA;
            prevB   = bus.quadB;
            prevPe  = bus.phase_err;
            prevCnt = bus.err_count;
        end
        if (cycle > 20000) begin
            $display("[TB] FAIL watchdog: got cycle %0d, expected completion before 20000", cycle);
            $fatal(1, "[TB] watchdog expired");
        end
        if (finishReq) begin
            while (expQ.size() > 0) begin
                evt_t e;
                e = expQ.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_%s: got no event, expected %0h at cycle %0d", kindName(e.kind), e.val, e.cyc);
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic idx);
        bus.quadA_raw = a;
        bus.quadB_raw = b;
        bus.index_raw = idx;
    endtask

    task automatic pulseFiltWr(input logic [7:0] len);
        bus.filt_len = len;
        bus.filt_wr  = 1'b1;
        waitCycles(1);
        bus.filt_wr  = 1'b0;
    endtask

    // Directed scenarios; raw changes are applied just after an edge, so an
    // event expected at t+N appears N edges after the change
    initial begin
        int t;
        int r;
        reset        = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.filt_len = 8'd0;
        bus.filt_wr  = 1'b0;
        bus.err_clr  = 1'b0;
        waitCycles(4);
        reset = 1'b0;
        waitCycles(10);

        $display("[TB] A rise held stable, latency 6");
        t = cycle;
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectEvent(t + 6, K_A, 16'h1);
        waitCycles(12);

        $display("[TB] 3-cycle B glitch rejected");
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(12);

        $display("[TB] 4-cycle B pulse passes");
        t = cycle;
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectEvent(t + 6, K_B, 16'h1);
        expectEvent(t + 10, K_B, 16'h0);
        waitCycles(4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitCycles(12);

        $display("[TB] simultaneous A/B toggles");
        t = cycle;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectEvent(t + 6, K_A, 16'h0);
        expectEvent(t + 6, K_B, 16'h1);
        expectEvent(t + 6, K_PE, 16'h1);
        expectEvent(t + 6, K_CNT, 16'h1);
        waitCycles(12);

        t = cycle;
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectEvent(t + 6, K_A, 16'h1);
        expectEvent(t + 6, K_B, 16'h0);
        expectEvent(t + 6, K_CNT, 16'h2);
        waitCycles(12);

        $display("[TB] phase error coincident with err_clr");
        t = cycle;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectEvent(t + 6, K_A, 16'h0);
        expectEvent(t + 6, K_B, 16'h1);
        expectEvent(t + 6, K_CNT, 16'h1);
        waitCycles(5);
        bus.err_clr = 1'b1;
        waitCycles(1);
        bus.err_clr = 1'b0;
        waitCycles(8);

        t = cycle;
        bus.err_clr = 1'b1;
        expectEvent(t + 1, K_PE, 16'h0);
        expectEvent(t + 1, K_CNT, 16'h0);
        waitCycles(1);
        bus.err_clr = 1'b0;
        waitCycles(8);

        $display("[TB] index pulses: 6 cycles strobes, 3 cycles does not");
        t = cycle;
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectEvent(t + 7, K_STB, 16'h1);
        waitCycles(6);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(16);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(12);

        $display("[TB] filt_wr length 0 mid-filter");
        t = cycle;
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectEvent(t + 5, K_A, 16'h1);
        waitCycles(3);
        pulseFiltWr(8'd0);
        waitCycles(8);
        t = cycle;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectEvent(t + 3, K_A, 16'h0);
        waitCycles(8);
        t = cycle;
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectEvent(t + 3, K_B, 16'h0);
        waitCycles(8);
        t = cycle;
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectEvent(t + 3, K_B, 16'h1);
        expectEvent(t + 4, K_B, 16'h0);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitCycles(8);
        pulseFiltWr(8'd5);
        waitCycles(4);

        $display("[TB] length 5, then reset mid-filter with inputs high");
        t = cycle;
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectEvent(t + 8, K_A, 16'h1);
        expectEvent(t + 8, K_B, 16'h1);
        expectEvent(t + 8, K_PE, 16'h1);
        expectEvent(t + 8, K_CNT, 16'h1);
        waitCycles(10);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitCycles(4);
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        r = cycle;
        expectEvent(r + 3, K_A, 16'h1);
        expectEvent(r + 3, K_B, 16'h1);
        waitCycles(12);

        $display("[TB] default length restored by reset");
        t = cycle;
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectEvent(t + 6, K_A, 16'h0);
        waitCycles(10);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitCycles(10);
        t = cycle;
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectEvent(t + 7, K_STB, 16'h1);
        waitCycles(12);

        finishReq = 1'b1;
    end

endmodule

// File: doc/quad_enc_filter.md
QUAD_ENC_FILTER -- requirements
Module: quad_enc_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops per raw input; legal range 2-4.
REQ-002 Parameter FILT_W, default 8, width of the filter-length register and of each filter counter.
REQ-003 Parameter FILT_DEFAULT, default 3, filter length loaded at reset.
REQ-004 clk_i  in  1  single block clock; every flop in the block is clocked on its rising edge.
REQ-005 reset  in  1  reset; synchronous, active-high.
REQ-006 quadA_raw, quadB_raw, index_raw  in  1 each  asynchronous encoder pins.
REQ-007 filt_len  in  FILT_W  new filter length; sampled when filt_wr=1.
REQ-008 filt_wr  in  1  single-cycle load strobe for filt_len.
REQ-009 err_clr  in  1  single-cycle clear for the phase-error status.
REQ-010 quadA, quadB  out  1 each  filtered levels that feed the quadrature counter.
REQ-011 index_strobe  out  1  one-cycle pulse on each filtered rising edge of index.
REQ-012 phase_err  out  1  sticky flag; set when filtered A and B change in the same cycle.
REQ-013 err_count  out  16  saturating count of phase errors.

Function
REQ-014 Each raw input SHALL pass through a SYNC_STAGES-deep flop chain before any other logic uses it.
REQ-015 Per channel: a synced value different from the filtered output SHALL increment that channel's counter; a synced value equal to the filtered output SHALL clear it.
REQ-016 When a mismatch exists and the counter equals filt_len_reg, the filtered output SHALL take the synced value and the counter SHALL clear in the same cycle.
REQ-017 A raw change held stable SHALL reach the output exactly SYNC_STAGES+filt_len_reg+1 cycles later; filt_len_reg=0 gives SYNC_STAGES+1.
REQ-018 A raw pulse shorter than filt_len_reg+1 synced cycles SHALL leave the output unchanged.
REQ-019 Counters SHALL NOT wrap; a counter holds at its maximum value, which cannot be exceeded because filt_len_reg <= 2^FILT_W-1.
REQ-020 On filt_wr, filt_len_reg SHALL load filt_len and all three filter counters SHALL clear in the same cycle; outputs are unaffected.
REQ-021 Control FSM states are PRIME and RUN; reset SHALL force PRIME.
REQ-022 PRIME SHALL last SYNC_STAGES+1 cycles. On its final cycle all filtered outputs SHALL load the synced values directly, and the FSM SHALL then enter RUN.
REQ-023 In PRIME, index_strobe, phase_err and err_count SHALL NOT change.
REQ-024 RUN SHALL hold until reset.
REQ-025 In RUN, index_strobe SHALL be 1 for exactly the one cycle after filtered index goes 0->1.
REQ-026 In RUN, a cycle in which both filtered A and filtered B toggle SHALL set phase_err and increment err_count, saturating at 16'hFFFF.
REQ-027 err_clr SHALL clear phase_err and err_count to 0.
REQ-028 If err_clr and a new phase error occur in the same cycle, the result SHALL be phase_err=1 and err_count=1.

Reset
REQ-029 While reset=1, all of the following SHALL be 0 at the next edge: synchroniser flops, filtered outputs, counters, index_strobe, phase_err and err_count.
REQ-030 While reset=1, filt_len_reg SHALL become FILT_DEFAULT and the FSM SHALL become PRIME.
REQ-031 Reset asserted mid-filter SHALL discard the pending transition; no output pulse is produced by reset or by its release.

Structure
REQ-032 Package quad_enc_pkg SHALL hold the FSM state typedef (PRIME, RUN) and the default constants for SYNC_STAGES, FILT_W and FILT_DEFAULT.
REQ-033 One sub-module, quad_enc_glitch_filt (synchroniser plus counter filter, one channel), SHALL be instantiated three times.
REQ-034 Edge detection, phase check, error counter and FSM SHALL reside in quad_enc_filter.

Verification (SYNC_STAGES=2, filt_len_reg=3 unless stated)
REQ-035 Set quadA_raw 0->1 at cycle 10 and hold it -> quadA=1 from cycle 16, and no earlier.
REQ-036 Drive a 3-cycle high glitch on quadB_raw -> quadB stays 0, phase_err stays 0.
REQ-037 Toggle quadA_raw and quadB_raw in the same cycle -> both outputs change in the same cycle; phase_err=1, err_count=1. Repeat with err_clr coincident -> phase_err=1, err_count=1.
REQ-038 Drive a 6-cycle index_raw pulse -> exactly one index_strobe pulse, 7 cycles after the rising edge. A second pulse of 3 cycles -> no strobe.
REQ-039 Hold all raw inputs at 1 through reset and release it -> quadA=quadB=1 after the 3-cycle PRIME; no index_strobe; phase_err=0.
REQ-040 Apply filt_wr with filt_len=0 mid-filter -> the pending count is discarded; the next change appears 3 cycles after the raw edge.
